// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the burst-master state encoding.
package axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      STATUS
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam logic [3:0] AXI_CACHE_MOD   = 4'b0011;
   localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: a command becomes one AW/W/B or
// AR/R transaction, and the worst response plus ID/last errors are reported.
module axi_burst_master
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,

   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,

   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,

   output logic                  sts_valid,
   input  logic                  sts_ready,
   output logic [1:0]            sts_resp,
   output logic                  sts_err,

   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            resp_q, resp_d;
   logic                  err_q, err_d;
   logic                  last_beat;
   logic                  run;

   assign last_beat = (cnt_q == len_q);
   // Handshake outputs are masked while rst is high so nothing looks live
   // in the reset cycle itself.
   assign run       = !rst;

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            id_d    = cmd_id;
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            cnt_d   = 8'd0;
            resp_d  = AXI_RESP_OKAY;
            err_d   = 1'b0;
            state_d = cmd_write ? WR_ADDR : RD_ADDR;
         end
         WR_ADDR: if (m_axi_awready) state_d = WR_DATA;
         WR_DATA: if (wr_valid && m_axi_wready) begin
            cnt_d = cnt_q + 8'd1;
            if (last_beat) state_d = WR_RESP;
         end
         WR_RESP: if (m_axi_bvalid) begin
            resp_d  = m_axi_bresp;
            err_d   = err_q | (m_axi_bid != id_q);
            state_d = STATUS;
         end
         RD_ADDR: if (m_axi_arready) state_d = RD_DATA;
         RD_DATA: if (m_axi_rvalid && rd_ready) begin
            cnt_d = cnt_q + 8'd1;
            if (m_axi_rresp > resp_q) resp_d = m_axi_rresp;
            err_d = err_q | (m_axi_rid != id_q) | (m_axi_rlast != last_beat);
            // An early rlast from the slave ends the burst regardless of len.
            if (m_axi_rlast || last_beat) state_d = STATUS;
         end
         STATUS: if (sts_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= AXI_RESP_OKAY;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready     = run && (state_q == IDLE);
   assign sts_valid     = run && (state_q == STATUS);
   assign sts_resp      = resp_q;
   assign sts_err       = err_q;

   assign m_axi_awid    = id_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = AXI_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = AXI_CACHE_MOD;
   assign m_axi_awprot  = AXI_PROT_NONE;
   assign m_axi_awvalid = run && (state_q == WR_ADDR);

   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = (state_q == WR_DATA) && last_beat;
   assign m_axi_wvalid  = run && (state_q == WR_DATA) && wr_valid;
   assign wr_ready      = run && (state_q == WR_DATA) && m_axi_wready;
   assign m_axi_bready  = run && (state_q == WR_RESP);

   assign m_axi_arid    = id_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = AXI_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = AXI_CACHE_MOD;
   assign m_axi_arprot  = AXI_PROT_NONE;
   assign m_axi_arvalid = run && (state_q == RD_ADDR);

   assign rd_data       = m_axi_rdata;
   assign rd_last       = (state_q == RD_DATA) && last_beat;
   assign rd_valid      = run && (state_q == RD_DATA) && m_axi_rvalid;
   assign m_axi_rready  = run && (state_q == RD_DATA) && rd_ready;

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits (multiple of 8, STRB_WIDTH a power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte lanes.
REQ-004 SHALL have parameter ID_WIDTH, default 8, AXI ID width.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have the command port: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_id in ID_WIDTH; cmd_addr in ADDR_WIDTH; cmd_len in 8 (beats-1).
REQ-007 SHALL have the write-data stream: wr_data in DATA_WIDTH; wr_strb in STRB_WIDTH; wr_valid in 1; wr_ready out 1.
REQ-008 SHALL have the read-data stream: rd_data out DATA_WIDTH; rd_last out 1; rd_valid out 1; rd_ready in 1.
REQ-009 SHALL have the status port: sts_valid out 1; sts_ready in 1; sts_resp out 2 (worst AXI response seen); sts_err out 1 (ID/last protocol violation).
REQ-010 SHALL have the full AXI4 master port m_axi_aw*/w*/b*/ar*/r* (id, addr, len, size, burst, lock, cache, prot, valid, ready; wdata, wstrb, wlast; bid, bresp; rid, rdata, rresp, rlast).

Function
REQ-011 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, STATUS; one transaction in flight.
REQ-012 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, register id/addr/len, clear resp/err, go to WR_ADDR or RD_ADDR per cmd_write.
REQ-013 SHALL drive awsize/arsize = log2(STRB_WIDTH), burst = 2'b01 (INCR), lock 0, cache 4'b0011, prot 3'b000, constant.
REQ-014 SHALL hold awvalid (arvalid) high with stable fields from WR_ADDR (RD_ADDR) entry until ready; on handshake go to WR_DATA (RD_DATA).
REQ-015 SHALL in WR_DATA connect m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata/wstrb pass-through; wlast high when beat counter equals registered len.
REQ-016 SHALL count write beats on wvalid&&wready; counter 8 bits, zeroed on command accept; after last beat go to WR_RESP.
REQ-017 SHALL hold bready high in WR_RESP; on bvalid record bresp, set err if bid != registered id, go to STATUS.
REQ-018 SHALL in RD_DATA connect rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data=rdata; rd_last=1 on the beat where counter equals len.
REQ-019 SHALL per read beat update resp to max(resp, rresp); set err if rid mismatch or rlast disagrees with counter==len.
REQ-020 SHALL leave RD_DATA on the accepted beat with rlast=1, or counter==len, whichever first (rlast terminates early).
REQ-021 SHALL hold wr_ready, m_axi_wvalid, rd_valid, m_axi_rready, bready low outside their states.
REQ-022 SHALL in STATUS hold sts_valid with stable sts_resp/sts_err until sts_ready, then go to IDLE; cmd_ready rises the following cycle.
REQ-023 SHALL add zero bubble cycles within a burst: one beat per cycle when both sides are ready.
REQ-024 SHALL latch len 0 as a single-beat burst with wlast/rd_last on the first beat.

Reset
REQ-025 SHALL on rst return to IDLE and drive every valid/ready output (cmd_ready, wr_ready, rd_valid, sts_valid, awvalid, wvalid, bready, arvalid, rready) to 0, counter 0, sts_resp 0, sts_err 0.
REQ-026 SHALL on rst mid-burst abandon the transaction without status; cmd_ready asserts the cycle after rst deasserts.

Structure
REQ-027 SHALL place state encoding, AXI burst/resp constants (INCR, OKAY, SLVERR, DECERR) in shared package axi_pkg.
REQ-028 SHALL be a single module; no sub-modules required.

Verification
REQ-029 SHALL verify write: cmd addr 0x0100, len 3, data 0x11..0x44, strb 0xF against AXI4 RAM model -> AW len 3, wlast on 4th beat, sts_resp 0, sts_err 0.
REQ-030 SHALL verify read-back: read addr 0x0100, len 3 -> rd_data 0x11,0x22,0x33,0x44, rd_last on 4th only, sts_resp 0.
REQ-031 SHALL verify backpressure: random rd_ready/wr_valid gaps, len 15 -> all 16 beats in order, no beat lost or duplicated.
REQ-032 SHALL verify error: slave returns rresp 2'b10 on beat 2 and wrong bid -> sts_resp 2'b10; sts_err 1 on write.
REQ-033 SHALL verify rst asserted during beat 2 of an 8-beat write -> all valids 0 next cycle, no status, next command completes normally.
REQ-034 SHALL verify sts_ready held low 5 cycles -> sts fields stable, cmd_ready 0 until one cycle after handshake.
